// File: rtl/hazard3_div_seq.sv
// -----------------------------------------------------------------------------
// hazard3_div_seq
//
// Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
// Each accepted request runs XLEN iteration cycles (RUN) and then one
// finishing cycle (DONE). The finishing cycle applies the sign fix-up and
// registers the result. result_vld pulses for one cycle and result then holds.
//
// Optional feature: define HAZARD3_DIV_EARLY_OUT_EN to skip the iterations
// for divide-by-zero and signed overflow. These cases then go straight from
// IDLE to DONE. Without the macro they take the full iteration path. The
// iteration path gives the same values for these cases.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   op         - operation (funct3): 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_vld     - request strobe for op/op_a/op_b
//   op_rdy     - high when a request will be accepted (IDLE only)
//   op_kill    - aborts an in-flight operation / blocks acceptance
//   op_a       - dividend
//   op_b       - divisor
//   result     - quotient or remainder, holds outside result_vld
//   result_vld - single-cycle result strobe
// -----------------------------------------------------------------------------
module hazard3_div_seq #(
  parameter int XLEN    = 32,
  parameter int W_MULOP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_MULOP-1:0] op,
  input  logic               op_vld,
  output logic               op_rdy,
  input  logic               op_kill,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic [XLEN-1:0]    result,
  output logic               result_vld
);

  localparam int W_CTR = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [W_CTR-1:0] CTR_INIT = W_CTR'(XLEN - 1);
  localparam logic [W_CTR-1:0] CTR_ZERO = {W_CTR{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              op_rdy_r;
  logic              result_vld_r;
  logic [XLEN-1:0]   result_r;

  // Iteration datapath state
  logic [XLEN-1:0]   quot_r;     // dividend shifts out of the top, quotient bits shift in
  logic [XLEN-1:0]   rem_r;      // partial remainder
  logic [XLEN-1:0]   dvs_r;      // divisor magnitude
  logic [W_CTR-1:0]  ctr_r;
  logic              rem_sel_r;  // 1: return remainder, 0: quotient
  logic              neg_q_r;
  logic              neg_r_r;

  logic              accept_s;
  logic              early_s;
  logic              op_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic              b_nonzero_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN:0]     sh_s;
  logic              borrow_s;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [XLEN-1:0]   q_fix_s;
  logic [XLEN-1:0]   r_fix_s;
  logic              finish_s;

  assign accept_s    = op_vld & (state_r == S_IDLE) & ~op_kill & op[2];
  assign op_signed_s = ~op[0];
  assign a_neg_s     = op_signed_s & op_a[XLEN-1];
  assign b_neg_s     = op_signed_s & op_b[XLEN-1];
  assign b_nonzero_s = |op_b;
  assign a_mag_s     = a_neg_s ? (-op_a) : op_a;
  assign b_mag_s     = b_neg_s ? (-op_b) : op_b;

`ifdef HAZARD3_DIV_EARLY_OUT_EN
  logic ovf_s;
  assign ovf_s   = op_signed_s & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == {XLEN{1'b1}});
  assign early_s = ~b_nonzero_s | ovf_s;
`else
  assign early_s = 1'b0;
`endif

  // One restoring step: the trial subtraction only commits when it does not
  // borrow. The committed difference is always below the divisor, so the
  // XLEN-bit subtraction is exact.
  assign sh_s      = {rem_r, quot_r[XLEN-1]};
  assign borrow_s  = sh_s < {1'b0, dvs_r};
  assign rem_nxt_s = borrow_s ? sh_s[XLEN-1:0] : (sh_s[XLEN-1:0] - dvs_r);

  assign q_fix_s  = neg_q_r ? (-quot_r) : quot_r;
  assign r_fix_s  = neg_r_r ? (-rem_r) : rem_r;
  assign finish_s = (state_r == S_DONE) & ~op_kill;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = early_s ? S_DONE : S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (op_kill) begin
          state_nxt_s = S_IDLE;
        end else if (ctr_r == CTR_ZERO) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_rdy_r     <= 1'b1;
      result_vld_r <= 1'b0;
      result_r     <= {XLEN{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      op_rdy_r     <= (state_nxt_s == S_IDLE);
      result_vld_r <= finish_s;
      if (finish_s) begin
        result_r <= rem_sel_r ? r_fix_s : q_fix_s;
      end
    end
  end

  // Operand capture on accept, then one division step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_r    <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      dvs_r     <= {XLEN{1'b0}};
      ctr_r     <= CTR_ZERO;
      rem_sel_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else if (accept_s) begin
      dvs_r     <= b_mag_s;
      ctr_r     <= CTR_INIT;
      rem_sel_r <= op[1];
      // A zero divisor keeps the quotient at all-ones, with no negation
      neg_q_r   <= (a_neg_s ^ b_neg_s) & b_nonzero_s;
      neg_r_r   <= a_neg_s;
`ifdef HAZARD3_DIV_EARLY_OUT_EN
      if (!b_nonzero_s) begin
        quot_r <= {XLEN{1'b1}};
        rem_r  <= a_mag_s;
      end else if (early_s) begin
        // Signed overflow: the magnitude 2^(XLEN-1) negates to itself
        quot_r <= {1'b1, {(XLEN-1){1'b0}}};
        rem_r  <= {XLEN{1'b0}};
      end else begin
        quot_r <= a_mag_s;
        rem_r  <= {XLEN{1'b0}};
      end
`else
      quot_r    <= a_mag_s;
      rem_r     <= {XLEN{1'b0}};
`endif
    end else if (state_r == S_RUN) begin
      quot_r <= {quot_r[XLEN-2:0], ~borrow_s};
      rem_r  <= rem_nxt_s;
      ctr_r  <= ctr_r - W_CTR'(1);
    end
  end

  assign op_rdy     = op_rdy_r;
  assign result_vld = result_vld_r;
  assign result     = result_r;

endmodule
